// File: rtl/cpu_pkg.sv
// Shared CPU pipeline widths and forwarding-source encoding.
package cpu_pkg;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam logic [AW-1:0] ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_WB,
        FWD_MEM,
        FWD_EX
    } fwd_sel_t;

endpackage

// File: rtl/operand_bypass.sv
// Resolves one source operand against the EX/MEM/WB producers.
// OFS_BYPASS_EN selects full forwarding; otherwise any producer match stalls.
module operand_bypass
    import cpu_pkg::*;
(
    input  logic          useSrc,
    input  logic [AW-1:0] idx,
    input  logic [DW-1:0] rfData,
    input  logic          exRegwrite,
    input  logic          exMemread,
    input  logic [AW-1:0] exWreg,
    input  logic [DW-1:0] exWdata,
    input  logic          memRegwrite,
    input  logic [AW-1:0] memWreg,
    input  logic [DW-1:0] memWdata,
    input  logic          wbRegwrite,
    input  logic [AW-1:0] wbWreg,
    input  logic [DW-1:0] wbWdata,
    output logic [DW-1:0] operand,
    output logic          hazard,
    output fwd_sel_t      sel
);

    logic live;
    logic exHit;
    logic memHit;
    logic wbHit;

    assign live   = useSrc && (idx != ZERO_REG);
    assign exHit  = live && exRegwrite  && (exWreg  == idx);
    assign memHit = live && memRegwrite && (memWreg == idx);
    assign wbHit  = live && wbRegwrite  && (wbWreg  == idx);

    // Youngest producer wins; without forwarding this names the blocking producer.
    always_comb begin
        sel = FWD_RF;
        if (exHit)
            sel = FWD_EX;
        else if (memHit)
            sel = FWD_MEM;
        else if (wbHit)
            sel = FWD_WB;
    end

`ifdef OFS_BYPASS_EN
    assign hazard = exHit && exMemread;

    always_comb begin
        operand = '0;
        case (sel)
            FWD_EX:  operand = exWdata;
            FWD_MEM: operand = memWdata;
            FWD_WB:  operand = wbWdata;
            default: operand = (idx == ZERO_REG) ? '0 : rfData;
        endcase
    end
`else
    logic unusedFwd;

    assign hazard    = exHit || memHit || wbHit;
    assign operand   = (idx == ZERO_REG) ? '0 : rfData;
    assign unusedFwd = ^{exMemread, exWdata, memWdata, wbWdata};
`endif

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: regfile addressing, bypass/hazard resolution, ID/EX slot.
// Build option: OFS_BYPASS_EN enables EX/MEM/WB forwarding (load-use stall only).
module operand_fetch_stage
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_rs,
    input  logic [AW-1:0] in_rt,
    input  logic          in_use_rs,
    input  logic          in_use_rt,
    input  logic [AW-1:0] in_rd,
    input  logic          in_regwrite,
    input  logic          in_memread,
    input  logic [DW-1:0] in_imm,
    output logic [AW-1:0] rf_raddr1,
    output logic [AW-1:0] rf_raddr2,
    input  logic [DW-1:0] rf_rdata1,
    input  logic [DW-1:0] rf_rdata2,
    input  logic          ex_regwrite,
    input  logic          ex_memread,
    input  logic [AW-1:0] ex_wreg,
    input  logic [DW-1:0] ex_wdata,
    input  logic          mem_regwrite,
    input  logic [AW-1:0] mem_wreg,
    input  logic [DW-1:0] mem_wdata,
    input  logic          wb_regwrite,
    input  logic [AW-1:0] wb_wreg,
    input  logic [DW-1:0] wb_wdata,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_op_a,
    output logic [DW-1:0] out_op_b,
    output logic [DW-1:0] out_imm,
    output logic [AW-1:0] out_rd,
    output logic          out_regwrite,
    output logic          out_memread,
    output logic [31:0]   stall_cnt
);

    logic [DW-1:0] opA;
    logic [DW-1:0] opB;
    logic          hazA;
    logic          hazB;
    fwd_sel_t      selA;
    fwd_sel_t      selB;
    logic          hazard;
    logic          load;
    logic          unusedSel;

    assign rf_raddr1 = in_rs;
    assign rf_raddr2 = in_rt;

    operand_bypass u_bypassA (
        .useSrc      (in_use_rs),
        .idx         (in_rs),
        .rfData      (rf_rdata1),
        .exRegwrite  (ex_regwrite),
        .exMemread   (ex_memread),
        .exWreg      (ex_wreg),
        .exWdata     (ex_wdata),
        .memRegwrite (mem_regwrite),
        .memWreg     (mem_wreg),
        .memWdata    (mem_wdata),
        .wbRegwrite  (wb_regwrite),
        .wbWreg      (wb_wreg),
        .wbWdata     (wb_wdata),
        .operand     (opA),
        .hazard      (hazA),
        .sel         (selA)
    );

    operand_bypass u_bypassB (
        .useSrc      (in_use_rt),
        .idx         (in_rt),
        .rfData      (rf_rdata2),
        .exRegwrite  (ex_regwrite),
        .exMemread   (ex_memread),
        .exWreg      (ex_wreg),
        .exWdata     (ex_wdata),
        .memRegwrite (mem_regwrite),
        .memWreg     (mem_wreg),
        .memWdata    (mem_wdata),
        .wbRegwrite  (wb_regwrite),
        .wbWreg      (wb_wreg),
        .wbWdata     (wb_wdata),
        .operand     (opB),
        .hazard      (hazB),
        .sel         (selB)
    );

    // Source selection is resolved inside the bypass units; kept only for debug visibility.
    assign unusedSel = ^{selA, selB};

    assign hazard   = hazA || hazB;
    assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
    assign load     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            out_op_a     <= '0;
            out_op_b     <= '0;
            out_imm      <= '0;
            out_rd       <= '0;
            out_regwrite <= 1'b0;
            out_memread  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid    <= 1'b1;
            out_op_a     <= opA;
            out_op_b     <= opB;
            out_imm      <= in_imm;
            out_rd       <= in_rd;
            out_regwrite <= in_regwrite;
            out_memread  <= in_memread;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (in_valid && hazard && !flush && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
    end

endmodule
